// File: rtl/iommu_msi_arb.sv
// MSI arbiter: round-robin grant of edge-latched interrupt sources to one MSI writer; ip_i to req_valid_o is 2 cycles.
// Backpressure: req_valid_o holds with stable src/vec until req_ready_i; one write in flight until done_i.
module iommu_msi_arb #(
  parameter int N_SRC = 4,
  parameter int N_VEC = 16,
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int VEC_W = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic [N_SRC-1:0]                ip_i,
  input  logic [N_SRC-1:0][VEC_W-1:0]     vec_i,
  input  logic [N_VEC-1:0]                vec_masked_i,
  output logic                            req_valid_o,
  input  logic                            req_ready_i,
  output logic [SRC_W-1:0]                req_src_o,
  output logic [VEC_W-1:0]                req_vec_o,
  input  logic                            done_i,
  input  logic                            err_i,
  output logic [N_SRC-1:0]                pend_o,
  output logic                            busy_o,
  output logic                            msi_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [VEC_W-1:0] vec;
  } grant_t;

  state_e             state;
  logic [N_SRC-1:0]   ip_q;
  logic [N_SRC-1:0]   pend;
  logic [N_SRC-1:0]   pend_nxt;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   ptr_nxt;
  logic [SRC_W:0]     cand_sum;
  logic [SRC_W:0]     ptr_sum;
  logic               gnt_vld;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_fire;
  grant_t             gnt_dat;
  grant_t             cur_dat;

  always_comb begin
    rise = ip_i & ~ip_q;
    eligible = '0;
    for (int s = 0; s < N_SRC; s++) begin
      eligible[s] = pend[s] & ~vec_masked_i[vec_i[s]];
    end
  end

  // Round-robin search starting at ptr; first eligible source wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand_sum = {1'b0, ptr} + (SRC_W+1)'(i);
      if (cand_sum >= (SRC_W+1)'(N_SRC)) begin
        cand_sum = cand_sum - (SRC_W+1)'(N_SRC);
      end
      if (!gnt_vld && eligible[cand_sum[SRC_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_sum[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, gnt_idx} + (SRC_W+1)'(1);
    if (ptr_sum >= (SRC_W+1)'(N_SRC)) begin
      ptr_sum = ptr_sum - (SRC_W+1)'(N_SRC);
    end
    ptr_nxt = ptr_sum[SRC_W-1:0];
  end

  assign gnt_fire    = (state == IDLE) && enable_i && gnt_vld;
  assign gnt_dat.src = gnt_idx;
  assign gnt_dat.vec = vec_i[gnt_idx];

  // A new edge on a source being granted this cycle keeps it pending.
  always_comb begin
    pend_nxt = pend;
    if (gnt_fire) begin
      pend_nxt[gnt_idx] = 1'b0;
    end
    if (enable_i) begin
      pend_nxt = pend_nxt | rise;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ip_q        <= '0;
      pend        <= '0;
      ptr         <= '0;
      cur_dat     <= '0;
      req_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      msi_err_o   <= 1'b0;
    end else begin
      ip_q      <= ip_i;
      pend      <= pend_nxt;
      msi_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_fire) begin
            state       <= ISSUE;
            cur_dat     <= gnt_dat;
            ptr         <= ptr_nxt;
            req_valid_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ISSUE: begin
          if (req_ready_i) begin
            state       <= WAIT;
            req_valid_o <= 1'b0;
          end
        end
        WAIT: begin
          if (done_i) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            msi_err_o <= err_i;
          end
        end
        default: begin
          state       <= IDLE;
          req_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  assign req_src_o = cur_dat.src;
  assign req_vec_o = cur_dat.vec;
  assign pend_o    = pend;

endmodule
